// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo digit counter: default sizing,
// prescaler width function and 7-segment codes (bit 0 = segment a, bit 6 = g).
package counter_pkg;

   localparam int DEF_WIDTH    = 4;
   localparam int DEF_MODULUS  = 6;
   localparam int DEF_PRESCALE = 6;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Bits needed to hold 0..n-1, never less than one so a divide-by-1 still has a register.
   function automatic int clog2_min1(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

   function automatic logic [6:0] seg_decode(input int unsigned d);
      logic [6:0] s;
      case (d)
         0:       s = SEG_0;
         1:       s = SEG_1;
         2:       s = SEG_2;
         3:       s = SEG_3;
         4:       s = SEG_4;
         5:       s = SEG_5;
         6:       s = SEG_6;
         7:       s = SEG_7;
         8:       s = SEG_8;
         9:       s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mod_digit_counter_prescaler.sv
// Enable-gated divide-by-PRESCALE counter; tick marks the enabled clock on which
// the owning digit steps. clear restarts the count and suppresses tick.
module prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clear,
   output logic tick
);

   localparam int            PW   = clog2_min1(PRESCALE);
   localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

   logic [PW-1:0] r_pre;
   logic          w_term;

   assign w_term = (r_pre == TERM);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pre <= '0;
      end else if (clear) begin
         r_pre <= '0;
      end else if (en) begin
         r_pre <= w_term ? '0 : r_pre + PW'(1);
      end
   end

   // Gating with reset keeps tick low while held in reset even when PRESCALE=1.
   assign tick = en & ~clear & reset & w_term;

endmodule

// File: rtl/mod_digit_counter.sv
// Single modulo digit with prescaler, up/down count, clamped synchronous load and
// carry/borrow output for cascading. Define DIGIT_SEG_EN to add the 7-segment output seg.
module mod_digit_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MODULUS  = DEF_MODULUS,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef DIGIT_SEG_EN
   output logic [6:0]       seg,
`endif
   output logic [WIDTH-1:0] out,
   output logic             tick,
   output logic             carry
);

   localparam logic [WIDTH-1:0] DIG_MAX = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] r_digit;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_load_clamped;
   logic             w_tick;
   logic             w_at_max;
   logic             w_at_zero;

   prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clear (load),
      .tick  (w_tick)
   );

   assign w_at_max  = (r_digit == DIG_MAX);
   assign w_at_zero = (r_digit == '0);

   always_comb begin
      w_next = r_digit;
      if (up_down) begin
         w_next = w_at_max ? '0 : r_digit + WIDTH'(1);
      end else begin
         w_next = w_at_zero ? DIG_MAX : r_digit - WIDTH'(1);
      end
   end

   // Out-of-range load values fall back to 0 so the digit never leaves 0..MODULUS-1.
   assign w_load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_digit <= '0;
      end else if (load) begin
         r_digit <= w_load_clamped;
      end else if (w_tick) begin
         r_digit <= w_next;
      end
   end

   assign out   = r_digit;
   assign tick  = w_tick;
   assign carry = w_tick & ((up_down & w_at_max) | (~up_down & w_at_zero));

`ifdef DIGIT_SEG_EN
   assign seg = seg_decode(32'(r_digit));
`endif

endmodule
